// File: rtl/luhn_card_gen.sv
`default_nettype none
// ============================================================================
//  Module   : luhn_card_gen
//  Purpose  : Builds a Luhn-valid card number of NUM_DIGITS decimal digits.
//             Random digits come from the RNG byte stream by rejection
//             sampling. Digits go out MSB-first on a valid/ready stream, and
//             the last digit is the Luhn check digit.
//  Options  : `define CARD_REJECT_CNT_EN adds a saturating counter of rejected
//             samples on reject_cnt. Without it, reject_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module luhn_card_gen #(
  parameter int NUM_DIGITS = 16,
  parameter int IIN_DIGIT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rand_in,
  input  logic       start,
  output logic       busy,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       digit_last,
  output logic       done,
  output logic [7:0] reject_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PFX  = 3'd1,
    S_SAMP = 3'd2,
    S_OUT  = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] IIN_NIB       = 4'(IIN_DIGIT);
  localparam bit         IIN_FIXED     = (IIN_DIGIT <= 9);
  localparam logic [5:0] LAST_RAND_IDX = 6'(NUM_DIGITS - 2);
  // A digit is doubled when its index has the same parity as NUM_DIGITS.
  localparam logic       DBL_PARITY    = 1'(NUM_DIGITS % 2);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  sum_q, sum_d;
  logic [3:0]  digit_q, digit_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  logic [3:0]  nib;
  logic        nib_ok;
  logic        xfer;
  logic        load;
  logic [3:0]  load_digit;
  logic [4:0]  weighted;
  logic [4:0]  sum_raw;
  logic [3:0]  check_digit;
  logic        unused_rand_hi;

  assign nib            = rand_in[3:0];
  assign nib_ok         = (nib <= 4'd9);
  assign xfer           = valid_q & digit_ready;
  assign unused_rand_hi = ^rand_in[7:4];

  // Luhn weighting of the digit being loaded, plus the mod-10 running sum and the check digit
  always_comb begin
    weighted = {1'b0, load_digit};
    if (idx_q[0] == DBL_PARITY) begin
      weighted = {load_digit, 1'b0};
      if (weighted > 5'd9) weighted = weighted - 5'd9;
    end
    sum_raw = {1'b0, sum_q} + weighted;
    if (sum_raw >= 5'd10) sum_raw = sum_raw - 5'd10;
    check_digit = (sum_q == 4'd0) ? 4'd0 : (4'd10 - sum_q);
  end

  // Next-state and datapath update for the digit generator
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    digit_d    = digit_q;
    valid_d    = valid_q;
    last_d     = last_q;
    load       = 1'b0;
    load_digit = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 6'd0;
          sum_d   = 4'd0;
          state_d = IIN_FIXED ? S_PFX : S_SAMP;
        end
      end
      S_PFX: begin
        load       = 1'b1;
        load_digit = IIN_NIB;
      end
      S_SAMP: begin
        if (nib_ok) begin
          load       = 1'b1;
          load_digit = nib;
        end
      end
      S_OUT: begin
        if (xfer) begin
          if (idx_q < LAST_RAND_IDX) begin
            idx_d   = idx_q + 6'd1;
            valid_d = 1'b0;
            state_d = S_SAMP;
          end else begin
            // Check digit follows back-to-back; valid stays high.
            digit_d = check_digit;
            last_d  = 1'b1;
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load) begin
      digit_d = load_digit;
      valid_d = 1'b1;
      sum_d   = sum_raw[3:0];
      state_d = S_OUT;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 6'd0;
      sum_q   <= 4'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef CARD_REJECT_CNT_EN
  logic [7:0] rej_q, rej_d;

  // Saturating count of rejected samples, restarted by each accepted start
  always_comb begin
    rej_d = rej_q;
    if (state_q == S_IDLE && start) begin
      rej_d = 8'd0;
    end else if (state_q == S_SAMP && !nib_ok && rej_q != 8'hFF) begin
      rej_d = rej_q + 8'd1;
    end
  end

  // Reject counter register
  always_ff @(posedge clk) begin
    if (!rst_n) rej_q <= 8'd0;
    else        rej_q <= rej_d;
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = 8'd0;
`endif

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign digit_last  = last_q;

endmodule
`default_nettype wire
